// File: rtl/vmerge_sorter_tree.sv
// Multi-way merge sorter: NW per-way batch FIFOs feed a min-key selector that emits one record per cycle.
// Optional macro VMERGE_SORTER_TREE_OUTREG_EN adds one more output register stage (latency 2).
`timescale 1ns/1ps
module vmerge_sorter_tree #(
  parameter int W_LOG     = 3,
  parameter int P_LOG     = 3,
  parameter int FIFO_SIZE = 2,
  parameter int DATW      = 64,
  parameter int KEYW      = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      IN_FULL,
  input  logic [(DATW<<P_LOG)-1:0]  din,
  input  logic                      dinen,
  input  logic [W_LOG-1:0]          din_idx,
  output logic [DATW-1:0]           dot,
  output logic                      doten,
  output logic [(1<<W_LOG)-1:0]     emp
);

  localparam int NW = 1 << W_LOG;
  localparam int NP = 1 << P_LOG;
  localparam int FD = 1 << FIFO_SIZE;
  localparam logic [FIFO_SIZE:0] FULL_CNT = (FIFO_SIZE+1)'(FD);

  typedef logic [NP-1:0][DATW-1:0] batch_t;

  batch_t               mem_q  [NW][FD];
  logic [FIFO_SIZE-1:0] wptr_q [NW];
  logic [FIFO_SIZE-1:0] rptr_q [NW];
  logic [FIFO_SIZE:0]   cnt_q  [NW];
  logic [FIFO_SIZE:0]   cnt_d  [NW];
  logic [P_LOG-1:0]     ridx_q [NW];

  logic [DATW-1:0]      head   [NW];
  logic [NW-1:0]        avail;
  logic [NW-1:0]        push;
  logic [NW-1:0]        cons;
  logic [NW-1:0]        pop;
  logic                 step;
  logic [W_LOG-1:0]     selIdx;
  logic [KEYW-1:0]      selKey;

  logic [DATW-1:0]      dot_q;
  logic                 doten_q;

  always_comb begin
    for (int i = 0; i < NW; i++) begin
      head[i]  = mem_q[i][rptr_q[i]][ridx_q[i]];
      avail[i] = (cnt_q[i] != '0);
      emp[i]   = (cnt_q[i] != FULL_CNT);
    end
  end

  // Strict less-than while scanning upward keeps ties on the lowest way index.
  always_comb begin
    selIdx = '0;
    selKey = head[0][KEYW-1:0];
    for (int i = 1; i < NW; i++) begin
      if (head[i][KEYW-1:0] < selKey) begin
        selIdx = W_LOG'(i);
        selKey = head[i][KEYW-1:0];
      end
    end
  end

  always_comb begin
    step = (&avail) && !IN_FULL;
    for (int i = 0; i < NW; i++) begin
      push[i]  = dinen && (din_idx == W_LOG'(i)) && emp[i];
      cons[i]  = step && (selIdx == W_LOG'(i));
      pop[i]   = cons[i] && (ridx_q[i] == '1);
      cnt_d[i] = cnt_q[i] + {{FIFO_SIZE{1'b0}}, push[i]} - {{FIFO_SIZE{1'b0}}, pop[i]};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NW; i++) begin
        cnt_q[i]  <= '0;
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        ridx_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NW; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (push[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
        if (cons[i]) ridx_q[i] <= ridx_q[i] + 1'b1;
        if (pop[i])  rptr_q[i] <= rptr_q[i] + 1'b1;
      end
    end
  end

  // Batch storage needs no reset; occupancy counters define what is valid.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NW; i++) begin
      if (push[i]) mem_q[i][wptr_q[i]] <= batch_t'(din);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dot_q   <= '0;
      doten_q <= 1'b0;
    end else begin
      doten_q <= step;
      if (step) dot_q <= head[selIdx];
    end
  end

`ifdef VMERGE_SORTER_TREE_OUTREG_EN
  logic [DATW-1:0] dot2_q;
  logic            doten2_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      dot2_q   <= '0;
      doten2_q <= 1'b0;
    end else begin
      doten2_q <= doten_q;
      if (doten_q) dot2_q <= dot_q;
    end
  end

  assign dot   = dot2_q;
  assign doten = doten2_q;
`else
  assign dot   = dot_q;
  assign doten = doten_q;
`endif

endmodule

// File: tb/tb_vmerge_sorter_tree.sv
// Directed self-checking bench for vmerge_sorter_tree (default parameters).
`timescale 1ns/1ps
module tb_vmerge_sorter_tree;

  localparam int DATW = 64;
  localparam int NP   = 8;
  localparam int NW   = 8;
`ifdef VMERGE_SORTER_TREE_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic                 IN_FULL = 1'b0;
  logic [DATW*NP-1:0]   din = '0;
  logic                 dinen = 1'b0;
  logic [2:0]           din_idx = '0;
  logic [DATW-1:0]      dot;
  logic                 doten;
  logic [NW-1:0]        emp;

  int total = 0;
  int bad   = 0;
  int expKey;

  vmerge_sorter_tree dut (
    .CLK     (CLK),
    .RST     (RST),
    .IN_FULL (IN_FULL),
    .din     (din),
    .dinen   (dinen),
    .din_idx (din_idx),
    .dot     (dot),
    .doten   (doten),
    .emp     (emp)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Called at a negedge; the batch is captured on the following posedge.
  task automatic applyStimulus(input int way, input logic [31:0] k0, input logic [31:0] kstep,
                               input logic [31:0] upper);
    for (int j = 0; j < NP; j++) din[DATW*j +: DATW] = {upper, k0 + 32'(j) * kstep};
    din_idx = 3'(way);
    dinen   = 1'b1;
    @(negedge CLK);
    dinen   = 1'b0;
  endtask

  task automatic doReset();
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int wantWay;

    @(negedge CLK);
    doReset();
    checkOutput("rst_emp",   64'(emp),   64'hFF);
    checkOutput("rst_doten", 64'(doten), 64'd0);
    checkOutput("rst_dot",   dot,        64'd0);

    // Overflow: four batches fill way 2, the fifth (keys 33..40) must be dropped.
    for (int b = 0; b < 4; b++) applyStimulus(2, 32'(1 + 8*b), 32'd1, 32'hFFFFFFFF);
    checkOutput("ovf_emp_full", 64'(emp), 64'hFB);
    applyStimulus(2, 32'd33, 32'd1, 32'hFFFFFFFF);
    checkOutput("ovf_emp_drop", 64'(emp), 64'hFB);
    for (int w = 0; w < NW; w++) if (w != 2) applyStimulus(w, 32'd1000, 32'd1, 32'hFFFFFFFF);
    n = 0;
    for (int c = 0; c < 80; c++) begin
      if (doten) begin
        checkOutput("ovf_dot", dot, {32'hFFFFFFFF, 32'(n + 1)});
        n++;
      end
      @(negedge CLK);
    end
    checkOutput("ovf_count",     64'(n),   64'd32);
    checkOutput("ovf_emp_after", 64'(emp), 64'hFF);

    // Reset with data still buffered in ways 0,1,3..7.
    doReset();
    checkOutput("rst2_emp",   64'(emp),   64'hFF);
    checkOutput("rst2_doten", 64'(doten), 64'd0);
    checkOutput("rst2_dot",   dot,        64'd0);

    // Partial fill: ways 0..6 only, no merge may happen.
    for (int w = 0; w < 7; w++) applyStimulus(w, 32'(w + 1), 32'd8, 32'hFFFFFFFF);
    for (int c = 0; c < 4; c++) begin
      checkOutput("part_idle", 64'(doten), 64'd0);
      @(negedge CLK);
    end
    applyStimulus(7, 32'd8, 32'd8, 32'hFFFFFFFF);
    checkOutput("part_lat0", 64'(doten), 64'd0);
    repeat (LAT) @(negedge CLK);
    checkOutput("part_first_en", 64'(doten), 64'd1);
    checkOutput("part_first",    dot,        {32'hFFFFFFFF, 32'd1});

    // Round-robin refill (6 batches per way) with a 5-cycle stall mid-stream.
    expKey = 2;
    fork
      begin : feeder
        int sent [NW];
        int ptr;
        int done;
        int w;
        bit found;
        ptr = 0;
        done = 0;
        w = 0;
        for (int i = 0; i < NW; i++) sent[i] = 1;
        for (int g = 0; g < 4000 && done < NW * 5; g++) begin
          found = 1'b0;
          for (int k = 0; k < NW && !found; k++) begin
            w = (ptr + k) % NW;
            if (sent[w] < 6 && emp[w]) found = 1'b1;
          end
          if (found) begin
            applyStimulus(w, 32'(w + 1 + 64 * sent[w]), 32'd8, 32'hFFFFFFFF);
            sent[w]++;
            done++;
            ptr = (w + 1) % NW;
          end else begin
            @(negedge CLK);
          end
        end
        checkOutput("feed_done", 64'(done), 64'd40);
      end
      begin : monitor
        int g;
        g = 0;
        while (expKey <= 377 && g < 5000) begin
          @(negedge CLK);
          g++;
          if (doten) begin
            checkOutput("rr_dot", dot, {32'hFFFFFFFF, 32'(expKey)});
            expKey++;
          end
        end
        checkOutput("rr_last", 64'(expKey), 64'd378);
        for (int c = 0; c < 10; c++) begin
          @(negedge CLK);
          checkOutput("rr_tail_idle", 64'(doten), 64'd0);
        end
      end
      begin : staller
        int g;
        g = 0;
        while (expKey < 100 && g < 5000) begin
          @(negedge CLK);
          g++;
        end
        IN_FULL = 1'b1;
        for (int k = 1; k <= 5; k++) begin
          @(negedge CLK);
          if (k >= LAT) checkOutput("stall_idle", 64'(doten), 64'd0);
        end
        IN_FULL = 1'b0;
      end
    join

    // Ties: ways 1 and 4 carry identical keys; way 1 must win each tie.
    doReset();
    for (int w = 0; w < NW; w++)
      if (w != 1 && w != 4) applyStimulus(w, 32'd1000, 32'd1, 32'hA0000000 | 32'(w));
    applyStimulus(1, 32'd10, 32'd1, 32'hA0000001);
    applyStimulus(4, 32'd10, 32'd1, 32'hA0000004);
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      @(negedge CLK);
      if (doten) begin
        wantWay = (n % 2 == 0) ? 1 : 4;
        checkOutput("tie_dot", dot, {32'hA0000000 | 32'(wantWay), 32'(10 + n / 2)});
        n++;
      end
    end
    checkOutput("tie_count", 64'(n), 64'd6);

    // Reset while the stream is still flowing.
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("rst3_doten", 64'(doten), 64'd0);
    checkOutput("rst3_dot",   dot,        64'd0);
    checkOutput("rst3_emp",   64'(emp),   64'hFF);
    RST = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      checkOutput("rst3_idle", 64'(doten), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vmerge_sorter_tree.md
VMERGE_SORTER_TREE -- requirements
Module: vmerge_sorter_tree

Interface
REQ-001 The block SHALL have parameter W_LOG, default 3: log2 of number of input ways (NW = 1<<W_LOG).
REQ-002 The block SHALL have parameter P_LOG, default 3: log2 of records per input batch (NP = 1<<P_LOG).
REQ-003 The block SHALL have parameter FIFO_SIZE, default 2: log2 of per-way FIFO depth in batches.
REQ-004 The block SHALL have parameter DATW, default 64: record width.
REQ-005 The block SHALL have parameter KEYW, default 32: sort key width, key = record[KEYW-1:0].
REQ-006 The block SHALL have port CLK, input, 1: clock, all logic on rising edge.
REQ-007 The block SHALL have port RST, input, 1: reset, synchronous, active-high.
REQ-008 The block SHALL have port IN_FULL, input, 1: downstream stall.
REQ-009 The block SHALL have port din, input, DATW<<P_LOG: one batch, record j at din[DATW*(j+1)-1:DATW*j].
REQ-010 The block SHALL have port dinen, input, 1: batch write strobe.
REQ-011 The block SHALL have port din_idx, input, W_LOG: target way of the batch.
REQ-012 The block SHALL have port dot, output, DATW: merged output record.
REQ-013 The block SHALL have port doten, output, 1: dot valid.
REQ-014 The block SHALL have port emp, output, 1<<W_LOG: emp[i]=1 when way i has at least one free batch slot.

Function
REQ-015 Each way SHALL hold a FIFO of 1<<FIFO_SIZE batches, plus a read index selecting the current record within the head batch.
REQ-016 When dinen=1 and emp[din_idx]=1, the batch SHALL be pushed into way din_idx; when emp[din_idx]=0 the write SHALL be silently dropped.
REQ-017 Records within a batch SHALL be consumed in order j=0..NP-1, and the batch popped after record NP-1; upstream guarantees batches and successive batches per way are ascending.
REQ-018 A merge step SHALL occur in a cycle only when every way has a head record available and IN_FULL=0.
REQ-019 A merge step SHALL select the way whose head key is the smallest (unsigned compare), ties going to the lowest way index, and consume that record.
REQ-020 The selected record SHALL appear on dot, full DATW bits unmodified, with doten=1 on the following cycle (latency 1).
REQ-021 doten SHALL be 0 in every cycle following a cycle with no merge step; dot SHALL hold its last value.
REQ-022 A push and a consume on the same way in the same cycle SHALL both take effect.
REQ-023 emp SHALL be derived from registered FIFO occupancy, so a batch popped in cycle t frees its slot from cycle t+1.
REQ-024 FIFO pointers SHALL wrap modulo 1<<FIFO_SIZE, and the output rate SHALL be one record per cycle while all ways stay non-empty.

Reset
REQ-025 RST=1 SHALL empty all FIFOs, clear read indices, and drive emp to all ones, doten to 0 and dot to 0 from the next cycle.
REQ-026 RST asserted mid-operation SHALL discard all buffered records and any pending output.

Configuration
REQ-027 With macro VMERGE_SORTER_TREE_OUTREG_EN defined, an extra output register stage SHALL be inserted, making dot/doten latency 2 cycles (IN_FULL still gating merge steps); without it the latency SHALL be 1 cycle.

Verification
REQ-028 Reset: after RST, emp=8'hFF, doten=0, dot=0.
REQ-029 Round-robin fill: W_LOG=3, P_LOG=3, way i batches keys i+1+8j (+64 per refill), upper bits all ones, each written when emp[i]=1 -> dot keys 1,2,3,... strictly consecutive, with upper bits all ones.
REQ-030 Partial fill: ways 0..6 filled, way 7 empty -> doten stays 0; write way 7 -> output starts at the minimum key one cycle after the merge begins.
REQ-031 Stall: IN_FULL=1 for 5 cycles mid-stream -> doten=0 throughout, no record lost or duplicated, sequence resumes in order.
REQ-032 Overflow: write way 2 five times with FIFO_SIZE=2 -> emp[2]=0 after the fourth write, fifth batch dropped.
REQ-033 Ties: equal head keys in ways 1 and 4 -> way 1's record is output first.
